// File: rtl/sd_block_buffer_if.sv
// sd_block_buffer_if
// Bus bundle for sd_block_buffer: the CPU-side Wishbone slave port and the
// sd_controller-side Wishbone master port.
//   slave  : view taken by sd_block_buffer (answers CPU, drives SD requests)
//   master : view taken by the environment (CPU + sd_controller)
interface sd_block_buffer_if;
    // CPU side
    logic          cpu_cyc;
    logic          cpu_stb;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [3:0]    cpu_sel;
    logic [31:0]   cpu_dat_w;
    logic [31:0]   cpu_dat_r;
    logic          cpu_ack;
    // sd_controller side
    logic          sd_cyc;
    logic          sd_stb;
    logic          sd_we;
    logic [31:0]   sd_addr;
    logic [4095:0] sd_dat_w;
    logic [4095:0] sd_dat_r;
    logic          sd_ack;

    modport slave (
        input  cpu_cyc, cpu_stb, cpu_we, cpu_addr, cpu_sel, cpu_dat_w,
        output cpu_dat_r, cpu_ack,
        output sd_cyc, sd_stb, sd_we, sd_addr, sd_dat_w,
        input  sd_dat_r, sd_ack
    );

    modport master (
        output cpu_cyc, cpu_stb, cpu_we, cpu_addr, cpu_sel, cpu_dat_w,
        input  cpu_dat_r, cpu_ack,
        input  sd_cyc, sd_stb, sd_we, sd_addr, sd_dat_w,
        output sd_dat_r, sd_ack
    );
endinterface

// File: rtl/sd_block_buffer.sv
// sd_block_buffer
// Single-block (512-byte) write-back cache between a CPU Wishbone port and an
// sd_controller that moves whole blocks.
//
// Ports:
//   clock      single clock, rising edge
//   reset      asynchronous, active-low
//   bus        sd_block_buffer_if.slave (CPU slave side + SD master side)
//   flush      (SD_BLOCK_BUFFER_FLUSH_EN only) request write-back of a dirty block
//   flush_done (SD_BLOCK_BUFFER_FLUSH_EN only) 1-cycle pulse when a flush finishes
//
// Parameter SDSC: 1 = sd_addr is a byte address, 0 = sd_addr is a block index.
// Optional feature macro: SD_BLOCK_BUFFER_FLUSH_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a CPU request (or a pending flush)
// WRITEBACK | writing the dirty buffered block back to the card
// FILL      | reading the requested block into the buffer
// HIT       | block present: ack the latched access if still requested
module sd_block_buffer #(
    parameter bit SDSC = 1'b1
) (
    input  logic clock,
    input  logic reset,
`ifdef SD_BLOCK_BUFFER_FLUSH_EN
    input  logic flush,
    output logic flush_done,
`endif
    sd_block_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        HIT       = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:2]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   dat_q, dat_d;
    logic [22:0]   tag_q, tag_d;
    logic          valid_q, valid_d;
    logic          dirty_q, dirty_d;
    logic [4095:0] buffer_q, buffer_d;
`ifdef SD_BLOCK_BUFFER_FLUSH_EN
    logic          flush_pending_q, flush_pending_d;
    logic          flush_op_q, flush_op_d;
    logic          flush_done_q, flush_done_d;
`endif

    logic          cpu_req;
    logic [22:0]   sd_blk;
    logic          unused_addr_bits;

    assign cpu_req          = bus.cpu_cyc & bus.cpu_stb;
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        we_d          = we_q;
        sel_d         = sel_q;
        dat_d         = dat_q;
        tag_d         = tag_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        buffer_d      = buffer_q;
`ifdef SD_BLOCK_BUFFER_FLUSH_EN
        flush_pending_d = flush_pending_q | flush;
        flush_op_d      = flush_op_q;
        flush_done_d    = 1'b0;
`endif
        sd_blk        = '0;
        bus.cpu_ack   = 1'b0;
        bus.cpu_dat_r = '0;
        bus.sd_cyc    = 1'b0;
        bus.sd_stb    = 1'b0;
        bus.sd_we     = 1'b0;
        bus.sd_dat_w  = '0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d = bus.cpu_addr[31:2];
                    we_d   = bus.cpu_we;
                    sel_d  = bus.cpu_sel;
                    dat_d  = bus.cpu_dat_w;
                    if (valid_q && (tag_q == bus.cpu_addr[31:9]))
                        state_d = HIT;
                    else if (valid_q && dirty_q)
                        state_d = WRITEBACK;
                    else
                        state_d = FILL;
                end
`ifdef SD_BLOCK_BUFFER_FLUSH_EN
                // A flush is only serviced when no CPU request competes for IDLE.
                else if (flush_pending_q || flush) begin
                    flush_pending_d = 1'b0;
                    if (valid_q && dirty_q) begin
                        flush_op_d = 1'b1;
                        state_d    = WRITEBACK;
                    end else begin
                        flush_done_d = 1'b1;
                    end
                end
`endif
            end

            WRITEBACK: begin
                bus.sd_cyc   = 1'b1;
                bus.sd_stb   = 1'b1;
                bus.sd_we    = 1'b1;
                sd_blk       = tag_q;
                bus.sd_dat_w = buffer_q;
                if (bus.sd_ack) begin
                    dirty_d = 1'b0;
`ifdef SD_BLOCK_BUFFER_FLUSH_EN
                    if (flush_op_q) begin
                        flush_op_d   = 1'b0;
                        flush_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = FILL;
                    end
`else
                    state_d = FILL;
`endif
                end
            end

            FILL: begin
                bus.sd_cyc = 1'b1;
                bus.sd_stb = 1'b1;
                sd_blk     = addr_q[31:9];
                if (bus.sd_ack) begin
                    buffer_d = bus.sd_dat_r;
                    tag_d    = addr_q[31:9];
                    valid_d  = 1'b1;
                    dirty_d  = 1'b0;
                    state_d  = HIT;
                end
            end

            HIT: begin
                // Requester may have given up during a fill; the block stays cached.
                if (cpu_req) begin
                    bus.cpu_ack = 1'b1;
                    if (we_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (sel_q[b])
                                buffer_d[{addr_q[8:2], b[1:0], 3'b000} +: 8] =
                                    dat_q[{b[1:0], 3'b000} +: 8];
                        end
                        dirty_d = 1'b1;
                    end else begin
                        bus.cpu_dat_r = buffer_q[{addr_q[8:2], 5'b00000} +: 32];
                    end
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        bus.sd_addr = SDSC ? {sd_blk, 9'b0} : {9'b0, sd_blk};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
`ifdef SD_BLOCK_BUFFER_FLUSH_EN
            flush_pending_q <= 1'b0;
            flush_op_q      <= 1'b0;
            flush_done_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
`ifdef SD_BLOCK_BUFFER_FLUSH_EN
            flush_pending_q <= flush_pending_d;
            flush_op_q      <= flush_op_d;
            flush_done_q    <= flush_done_d;
`endif
        end
    end

    // Block storage has no reset; valid_q guards its use.
    always_ff @(posedge clock) begin
        buffer_q <= buffer_d;
    end

`ifdef SD_BLOCK_BUFFER_FLUSH_EN
    assign flush_done = flush_done_q;
`endif

endmodule

// File: tb/tb_sd_block_buffer.sv
module tb_sd_block_buffer;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   sd_xfers = 0;

    sd_block_buffer_if bus0();
    sd_block_buffer_if bus1();

    // Second instance (SDSC=0) sees identical stimulus.
    assign bus1.cpu_cyc   = bus0.cpu_cyc;
    assign bus1.cpu_stb   = bus0.cpu_stb;
    assign bus1.cpu_we    = bus0.cpu_we;
    assign bus1.cpu_addr  = bus0.cpu_addr;
    assign bus1.cpu_sel   = bus0.cpu_sel;
    assign bus1.cpu_dat_w = bus0.cpu_dat_w;
    assign bus1.sd_dat_r  = bus0.sd_dat_r;
    assign bus1.sd_ack    = bus0.sd_ack;

`ifdef SD_BLOCK_BUFFER_FLUSH_EN
    logic flush;
    logic flush_done0;
    logic flush_done1;
    sd_block_buffer #(.SDSC(1'b1)) u_dut0 (.clock(clock), .reset(reset),
        .flush(flush), .flush_done(flush_done0), .bus(bus0));
    sd_block_buffer #(.SDSC(1'b0)) u_dut1 (.clock(clock), .reset(reset),
        .flush(flush), .flush_done(flush_done1), .bus(bus1));
`else
    sd_block_buffer #(.SDSC(1'b1)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
    sd_block_buffer #(.SDSC(1'b0)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] data;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [22:0] blk;
        logic [31:0] w0;
    } sd_exp_t;

    cpu_exp_t cpu_q[$];
    sd_exp_t  sd_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cpu(input logic we, input logic [31:0] data);
        cpu_exp_t e;
        e.we = we;
        e.data = data;
        cpu_q.push_back(e);
    endtask

    task automatic push_sd(input logic we, input logic [22:0] blk, input logic [31:0] w0);
        sd_exp_t e;
        e.we = we;
        e.blk = blk;
        e.w0 = w0;
        sd_q.push_back(e);
    endtask

    // Card model: answers every transfer after 3 cycles; block b word k = {A0, b[7:0], k}.
    initial begin
        int wait_cnt;
        logic [22:0] blk;
        wait_cnt = 0;
        bus0.sd_ack = 1'b0;
        bus0.sd_dat_r = '0;
        forever begin
            @(posedge clock);
            #1;
            if (bus0.sd_ack) begin
                bus0.sd_ack = 1'b0;
                wait_cnt = 0;
            end else if (reset && bus0.sd_cyc && bus0.sd_stb) begin
                wait_cnt++;
                if (wait_cnt == 3) begin
                    blk = bus0.sd_addr[31:9];
                    for (int k = 0; k < 128; k++)
                        bus0.sd_dat_r[32*k +: 32] = {8'hA0, blk[7:0], 16'(k)};
                    bus0.sd_ack = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT acks the CPU or starts an SD transfer.
    initial begin
        logic prev_cyc;
        logic prev_ack;
        cpu_exp_t ce;
        sd_exp_t se;
        prev_cyc = 1'b0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (bus0.cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check("unexpected_cpu_ack", 1, 0);
                end else begin
                    ce = cpu_q.pop_front();
                    if (!ce.we) begin
                        check("rd_data_sdsc1", bus0.cpu_dat_r, ce.data);
                        check("rd_data_sdsc0", bus1.cpu_dat_r, ce.data);
                    end
                end
            end else begin
                check("dat_r_zero_without_ack", bus0.cpu_dat_r, 0);
            end
            if (bus0.sd_cyc && (!prev_cyc || prev_ack)) begin
                sd_xfers++;
                if (sd_q.size() == 0) begin
                    check("unexpected_sd_xfer", 1, 0);
                end else begin
                    se = sd_q.pop_front();
                    check("sd_we", bus0.sd_we, se.we);
                    check("sd_stb", bus0.sd_stb, 1);
                    check("sd_addr_sdsc1", bus0.sd_addr, {se.blk, 9'b0});
                    check("sd_addr_sdsc0", bus1.sd_addr, {9'b0, se.blk});
                    if (se.we)
                        check("wb_word0", bus0.sd_dat_w[31:0], se.w0);
                end
            end
            prev_cyc = bus0.sd_cyc;
            prev_ack = bus0.sd_ack;
        end
    end

    task automatic raise_req(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] dat);
        @(posedge clock);
        #1;
        bus0.cpu_cyc = 1'b1;
        bus0.cpu_stb = 1'b1;
        bus0.cpu_we = we;
        bus0.cpu_addr = addr;
        bus0.cpu_sel = sel;
        bus0.cpu_dat_w = dat;
    endtask

    task automatic drop_req();
        bus0.cpu_cyc = 1'b0;
        bus0.cpu_stb = 1'b0;
        bus0.cpu_we = 1'b0;
    endtask

    // n = negedges from request to ack; a hit gives n == 2.
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] dat, input logic [31:0] exp, output int n);
        logic ok;
        push_cpu(we, exp);
        raise_req(we, addr, sel, dat);
        n = 0;
        ok = 1'b0;
        while (n < 100 && !ok) begin
            @(negedge clock);
            n++;
            if (bus0.cpu_ack) ok = 1'b1;
        end
        check("cpu_ack_seen", ok, 1);
        @(posedge clock);
        #1;
        drop_req();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cpu_ack"}, bus0.cpu_ack, 0);
        check({tag, "_cpu_dat_r"}, bus0.cpu_dat_r, 0);
        check({tag, "_sd_cyc"}, bus0.sd_cyc, 0);
        check({tag, "_sd_stb"}, bus0.sd_stb, 0);
        check({tag, "_sd_we"}, bus0.sd_we, 0);
        check({tag, "_sd_addr"}, bus0.sd_addr, 0);
        check({tag, "_sd_dat_w"}, |bus0.sd_dat_w, 0);
    endtask

    initial begin
        int n;
        int base;
        int guard;
        reset = 1'b0;
        bus0.cpu_cyc = 1'b0;
        bus0.cpu_stb = 1'b0;
        bus0.cpu_we = 1'b0;
        bus0.cpu_addr = '0;
        bus0.cpu_sel = '0;
        bus0.cpu_dat_w = '0;
`ifdef SD_BLOCK_BUFFER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;

        // Cold read: one fill of block 1, word 1.
        base = sd_xfers;
        push_sd(1'b0, 23'd1, 32'h0);
        cpu_access(1'b0, 32'h0000_0204, 4'hF, 32'h0, 32'hA001_0001, n);
        check("cold_read_xfers", sd_xfers - base, 1);

        // Hit reads/writes: no SD traffic, ack one cycle after sampling.
        base = sd_xfers;
        cpu_access(1'b0, 32'h0000_0208, 4'hF, 32'h0, 32'hA001_0002, n);
        check("hit_read_latency", n, 2);
        cpu_access(1'b1, 32'h0000_0200, 4'b0011, 32'hDEAD_BEEF, 32'h0, n);
        check("hit_write_latency", n, 2);
        cpu_access(1'b0, 32'h0000_0200, 4'hF, 32'h0, 32'hA001_BEEF, n);
        cpu_access(1'b1, 32'h0000_0204, 4'b0000, 32'hFFFF_FFFF, 32'h0, n);
        cpu_access(1'b0, 32'h0000_0204, 4'hF, 32'h0, 32'hA001_0001, n);
        check("hit_xfers", sd_xfers - base, 0);

        // Eviction of dirty block 1, then fill of block 2.
        base = sd_xfers;
        push_sd(1'b1, 23'd1, 32'hA001_BEEF);
        push_sd(1'b0, 23'd2, 32'h0);
        cpu_access(1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'hA002_0000, n);
        check("evict_xfers", sd_xfers - base, 2);

        // Requester leaves mid-fill: fill completes, block 3 then hits.
        base = sd_xfers;
        push_sd(1'b0, 23'd3, 32'h0);
        raise_req(1'b0, 32'h0000_0600, 4'hF, 32'h0);
        guard = 0;
        while (guard < 50 && !bus0.sd_cyc) begin @(negedge clock); guard++; end
        check("fill_started", bus0.sd_cyc, 1);
        @(posedge clock);
        #1;
        drop_req();
        guard = 0;
        while (guard < 50 && bus0.sd_cyc) begin @(negedge clock); guard++; end
        check("fill_finished", bus0.sd_cyc, 0);
        repeat (3) @(posedge clock);
        cpu_access(1'b0, 32'h0000_0604, 4'hF, 32'h0, 32'hA003_0001, n);
        check("after_drop_hit_latency", n, 2);
        check("drop_xfers", sd_xfers - base, 1);

        // Reset during write-back: outputs drop at once, dirty data lost.
        cpu_access(1'b1, 32'h0000_0600, 4'hF, 32'h1234_5678, 32'h0, n);
        push_sd(1'b1, 23'd3, 32'h1234_5678);
        raise_req(1'b0, 32'h0000_0800, 4'hF, 32'h0);
        guard = 0;
        while (guard < 50 && !bus0.sd_we) begin @(negedge clock); guard++; end
        check("wb_started", bus0.sd_we, 1);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_wb_reset");
        drop_req();
        @(posedge clock);
        #1;
        reset = 1'b1;
        base = sd_xfers;
        push_sd(1'b0, 23'd4, 32'h0);
        cpu_access(1'b0, 32'h0000_0800, 4'hF, 32'h0, 32'hA004_0000, n);
        check("post_reset_xfers", sd_xfers - base, 1);

`ifdef SD_BLOCK_BUFFER_FLUSH_EN
        cpu_access(1'b1, 32'h0000_0800, 4'hF, 32'hCAFE_F00D, 32'h0, n);
        for (int f = 0; f < 2; f++) begin
            base = sd_xfers;
            if (f == 0) push_sd(1'b1, 23'd4, 32'hCAFE_F00D);
            @(posedge clock);
            #1;
            flush = 1'b1;
            @(posedge clock);
            #1;
            flush = 1'b0;
            guard = 0;
            while (guard < 50 && !flush_done0) begin @(negedge clock); guard++; end
            check("flush_done_seen", flush_done0, 1);
            @(negedge clock);
            check("flush_done_pulse", flush_done0, 0);
            check("flush_xfers", sd_xfers - base, (f == 0) ? 1 : 0);
        end
`endif

        repeat (5) @(posedge clock);
        check("cpu_queue_empty", cpu_q.size(), 0);
        check("sd_queue_empty", sd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_block_buffer.md
SD_BLOCK_BUFFER -- requirements
Module: sd_block_buffer

Interface
REQ-001 Parameter SDSC, default 1: 1 = sd_addr is a byte address; 0 = sd_addr is a 512-byte block index.
REQ-002 Ports, one per line, name direction width meaning, clock and reset first:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_cyc  in  1  CPU-side Wishbone cycle.
- cpu_stb  in  1  CPU-side Wishbone strobe.
- cpu_we  in  1  1 = write.
- cpu_addr  in  32  byte address; [31:9] block, [8:2] word.
- cpu_sel  in  4  byte enables for writes.
- cpu_dat_w  in  32  write data.
- cpu_dat_r  out  32  read data.
- cpu_ack  out  1  one-cycle acknowledge.
- sd_cyc  out  1  sd_controller-side Wishbone cycle.
- sd_stb  out  1  sd_controller-side Wishbone strobe.
- sd_we  out  1  1 = block write.
- sd_addr  out  32  block address per REQ-001.
- sd_dat_w  out  4096  block to write; word k at bits [32k+31:32k].
- sd_dat_r  in  4096  block read.
- sd_ack  in  1  sd_controller completion.

Function
REQ-003 Holds exactly one 512-byte block: buffer[4095:0], tag[22:0], valid, dirty.
REQ-004 States: IDLE, WRITEBACK, FILL, HIT.
REQ-005 IDLE, cpu_cyc&cpu_stb high: latch addr, we, sel, dat_w. If valid and tag==addr[31:9], go to HIT. Else if valid&dirty, go to WRITEBACK. Else go to FILL.
REQ-006 WRITEBACK: sd_cyc=sd_stb=sd_we=1; sd_addr built from tag; sd_dat_w=buffer. On sd_ack: dirty<=0, go to FILL.
REQ-007 FILL: sd_cyc=sd_stb=1, sd_we=0; sd_addr built from latched addr[31:9]. On sd_ack: buffer<=sd_dat_r, tag<=addr[31:9], valid<=1, dirty<=0, go to HIT.
REQ-008 sd_addr = SDSC ? {blk,9'b0} : {9'b0,blk}.
REQ-009 sd_cyc, sd_stb, sd_we and sd_addr are held stable until sd_ack; they are 0 in IDLE and HIT.
REQ-010 HIT with cpu_cyc&cpu_stb still high:
- cpu_ack=1 for exactly this cycle.
- Read: cpu_dat_r = buffer word addr[8:2].
- Write: update bytes where sel=1; dirty<=1.
- Next state IDLE.
REQ-011 HIT with cpu_cyc or cpu_stb low: no ack and no write; go to IDLE. The filled block stays valid.
REQ-012 Hit latency: ack exactly 1 cycle after the request is sampled in IDLE. Back-to-back hits: one access per 2 cycles.
REQ-013 CPU input changes during WRITEBACK or FILL are ignored. An SD transfer, once started, always completes.
REQ-014 cpu_dat_r is valid only while cpu_ack is high, and 0 otherwise.
REQ-015 Write with sel=4'b0000 on a hit: ack issued, data unchanged, dirty still set.

Reset
REQ-016 reset low asynchronously forces: state IDLE; valid, dirty, tag = 0; every output 0.
REQ-017 buffer contents are not reset.
REQ-018 Reset mid-WRITEBACK or mid-FILL abandons the transfer; sd_cyc/sd_stb drop immediately and the dirty data is lost.

Configuration
REQ-019 Macro SD_BLOCK_BUFFER_FLUSH_EN defined: adds ports flush (in, 1) and flush_done (out, 1).
- In IDLE with no CPU request: valid&dirty -> WRITEBACK, then IDLE (no FILL); otherwise skip the transfer.
- flush_done pulses 1 cycle on return to IDLE.
- A CPU request in the same cycle wins; flush stays pending until serviced.
REQ-020 Macro undefined: no flush ports; dirty data is written only on eviction.

Verification
REQ-021 Scenarios:
- Reset, read 0x0000_0204 -> one FILL with sd_addr=0x0000_0200 (SDSC=1); cpu_dat_r = sd_dat_r[63:32]; no WRITEBACK.
- Read 0x0000_0208 after the above -> no SD traffic; ack 1 cycle after request.
- Write 0xDEADBEEF, sel=4'b0011 to 0x200 -> word 0 low half = 0xBEEF, upper half kept, dirty=1.
- Then read 0x0000_0400 -> WRITEBACK (sd_addr=0x200, word 0 updated), then FILL 0x400; with SDSC=0 the addresses are 1 and 2.
- Drop cpu_cyc mid-FILL -> fill completes, no cpu_ack, valid=1; the next read of the same block is a hit.
- reset low during WRITEBACK -> all outputs 0 at once; the next access issues FILL only.
- FLUSH_EN: dirty block, flush pulse -> one sd_we=1 transfer, flush_done 1 cycle; second flush -> flush_done with no SD traffic.
